// File: rtl/lopd_pkg.sv
// Shared helpers and default configuration for the leading-one detector / normaliser pipe.
package lopd_pkg;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_D_W     = 32;
    localparam int unsigned DEF_CHUNK_W = 8;
    localparam int unsigned DEF_TAG_W   = 4;
    localparam int unsigned POS_W       = clog2_f(DEF_D_W);
    localparam int unsigned NC          = DEF_D_W / DEF_CHUNK_W;

    typedef struct packed {
        logic [POS_W-1:0]     pos;
        logic                 zero;
        logic [DEF_D_W-1:0]   norm;
        logic [DEF_TAG_W-1:0] tag;
    } lopd_res_t;

endpackage

// File: rtl/lopd_chunk.sv
// Combinational priority encoder for one chunk: any-bit-set flag and leading-one index.
module lopd_chunk
    import lopd_pkg::*;
#(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0]         data,
    output logic                       nz,
    output logic [$clog2(CHUNK_W)-1:0] pos
);
    localparam int unsigned CP_W = clog2_f(CHUNK_W);

    always_comb begin
        nz  = |data;
        pos = '0;
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            if (data[i]) pos = CP_W'(i);
        end
    end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Two-stage elastic leading-one detector and normaliser with sideband tag.
module lopd_norm_pipe
    import lopd_pkg::*;
#(
    parameter int unsigned D_W     = DEF_D_W,
    parameter int unsigned CHUNK_W = DEF_CHUNK_W,
    parameter int unsigned TAG_W   = DEF_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [D_W-1:0]         in_data,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(D_W)-1:0] out_pos,
    output logic                   out_zero,
    output logic [D_W-1:0]         out_norm,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int unsigned P_W  = clog2_f(D_W);
    localparam int unsigned N_CH = D_W / CHUNK_W;
    localparam int unsigned CP_W = clog2_f(CHUNK_W);

    typedef struct packed {
        logic [P_W-1:0]   pos;
        logic             zero;
        logic [D_W-1:0]   norm;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic [N_CH-1:0]            cnz;
    logic [N_CH-1:0][CP_W-1:0]  cpos;

    logic                       s1_v;
    logic [N_CH-1:0]            s1_nz;
    logic [N_CH-1:0][CP_W-1:0]  s1_cpos;
    logic [D_W-1:0]             s1_data;
    logic [TAG_W-1:0]           s1_tag;

    logic                       s2_v;
    res_t                       s2_res;
    res_t                       res_d;

    logic                       s2_adv;
    logic                       in_acc;
    logic [P_W-1:0]             sel_pos;
    logic [P_W-1:0]             shamt;

    for (genvar c = 0; c < N_CH; c++) begin : g_chunk
        lopd_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
            .data (in_data[c*CHUNK_W +: CHUNK_W]),
            .nz   (cnz[c]),
            .pos  (cpos[c])
        );
    end

    assign s2_adv   = s1_v && (!s2_v || out_ready);
    assign in_ready = !s1_v || s2_adv;
    assign in_acc   = in_valid && in_ready;

    // Chunks are CHUNK_W-aligned, so OR-ing the chunk base with the in-chunk index is an add.
    always_comb begin
        sel_pos = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (s1_nz[c]) sel_pos = P_W'(c * CHUNK_W) | P_W'(s1_cpos[c]);
        end
        shamt      = P_W'(D_W - 1) - sel_pos;
        res_d.pos  = sel_pos;
        res_d.zero = ~|s1_nz;
        res_d.norm = (|s1_nz) ? (s1_data << shamt) : '0;
        res_d.tag  = s1_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_nz   <= '0;
            s1_cpos <= '0;
            s1_data <= '0;
            s1_tag  <= '0;
        end else begin
            if (in_acc) begin
                s1_v    <= 1'b1;
                s1_nz   <= cnz;
                s1_cpos <= cpos;
                s1_data <= in_data;
                s1_tag  <= in_tag;
            end else if (s2_adv) begin
                s1_v    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v        <= 1'b0;
            s2_res.pos  <= '0;
            s2_res.zero <= 1'b1;
            s2_res.norm <= '0;
            s2_res.tag  <= '0;
        end else begin
            if (s2_adv) begin
                s2_v   <= 1'b1;
                s2_res <= res_d;
            end else if (out_ready) begin
                s2_v   <= 1'b0;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_pos   = s2_res.pos;
    assign out_zero  = s2_res.zero;
    assign out_norm  = s2_res.norm;
    assign out_tag   = s2_res.tag;

endmodule
